modexp_sequencer: RTL and testbench
===================================

Name: modexp_sequencer

Overview:
- Left-to-right square-and-multiply sequencer for the modular-exponentiation datapath.
- Holds the public/private exponent register, scans exponent bits MSB to LSB, and issues one square or multiply-by-base operation at a time.
- Each operation is one multiply+modulo pass of the datapath, handshaked via `op_start`/`op_done`.
- Sits between the top-level input decoder (`load_e`/`start`) and the multiply/modulo datapath; replaces hand-sequencing of multiply/modulo enables.

Parameters:
- E_WIDTH, 16, exponent width in bits (>= 2).
- IDX_W, $clog2(E_WIDTH), width of `bit_idx`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_e  in  1  write `e_in` into the exponent register (IDLE only).
- e_in  in  E_WIDTH  new exponent value.
- start  in  1  begin exponentiation (IDLE only).
- op_done  in  1  datapath finished current operation (1-cycle pulse).
- busy  out  1  high in every state except IDLE.
- init_acc  out  1  1-cycle pulse: datapath loads accumulator with 1.
- op_start  out  1  1-cycle pulse: datapath begins an operation.
- op_sel  out  1  0 = square (acc*acc mod n), 1 = multiply (acc*base mod n); valid while `op_start` is high.
- bit_idx  out  IDX_W  exponent bit currently being processed.
- done  out  1  1-cycle pulse: result valid in datapath accumulator.

Behaviour:
- Reset (async, rst=1): state IDLE; exponent register = 0; shadow = 0; bit_idx = 0; busy, init_acc, op_start, op_sel, done = 0. Reset mid-operation aborts immediately; no `done` is produced.
- Outputs are Moore, decoded combinationally from state. `bit_idx` is registered.
- Exponent register:
  - Written on `load_e` only in IDLE.
  - `load_e` while busy is ignored; the register keeps its old value.
- States:
  - IDLE: on `start`, shadow <= (`load_e` ? `e_in` : exponent register). Same-cycle `load_e` also updates the register. bit_idx <= E_WIDTH-1. Go to INIT. `start` while busy is ignored.
  - INIT: `init_acc` = 1. If shadow == 0, go to DONE (result 1). Otherwise go to SQ_ISSUE.
  - SQ_ISSUE: `op_start` = 1, `op_sel` = 0. Go to SQ_WAIT.
  - SQ_WAIT: wait for `op_done`. Then:
    - if shadow[bit_idx] = 1, go to MUL_ISSUE;
    - else if bit_idx == 0, go to DONE;
    - else bit_idx-- and go to SQ_ISSUE.
  - MUL_ISSUE: `op_start` = 1, `op_sel` = 1. Go to MUL_WAIT.
  - MUL_WAIT: wait for `op_done`. Then if bit_idx == 0, go to DONE; else bit_idx-- and go to SQ_ISSUE.
  - DONE: `done` = 1. Go to IDLE.
- `op_done` is sampled only in the WAIT states; in any other state it is ignored.
- The datapath guarantees `op_done` no earlier than the cycle after `op_start`.
- Operation count = E_WIDTH squares + popcount(e) multiplies.
- Latency (op_done arriving 1 cycle after each op_start): 2 + 2*(ops) cycles from `start` sample to `done` pulse.
- `bit_idx` never wraps; the bit_idx == 0 check precedes any decrement.

Optional Feature:
- Macro: MODEXP_SKIP_LEADING_ZEROS_EN
- Defined:
  - In INIT with shadow != 0, bit_idx <= index of the highest set bit of shadow (priority encoder).
  - The first square at that bit is still issued (squares of 1 are harmless).
  - Squares = msb_index+1.
- Undefined: the scan always starts at E_WIDTH-1, as above.
- Result value is identical either way; only op count and latency differ.

Test Plan (E_WIDTH=4, datapath model returns op_done 1 cycle after op_start):
- Reset then idle: rst pulse -> all outputs 0, busy=0; `op_done` pulses in IDLE produce no state change.
- load_e with e_in=4'b1011, then start -> init_acc once; op sequence S,M,S,S,M,S,M with bit_idx 3,3,2,1,1,0,0; done 16 cycles after start; busy falls with done.
- e=0, start -> init_acc at cycle 1, done at cycle 2, zero op_start pulses.
- e=4'b0011 -> macro off: S,S,S,M,S,M (6 ops, done at cycle 14); macro on: S,M,S,M starting at bit_idx=1 (4 ops, done at cycle 10).
- load_e=1 with e_in=4'b0001 and start in the same IDLE cycle (old e=4'b1111) -> run uses 4'b0001 (4 squares, 1 multiply). load_e with 4'b1111 while busy -> register unchanged; the next run again uses 4'b0001.
- rst asserted during MUL_WAIT -> outputs 0 immediately, no done pulse, exponent register = 0; a subsequent start with e=0 completes normally.

Source files
------------

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving a multiply/modulo datapath.
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN starts the scan at the exponent's top set bit.
module modexp_sequencer #(
  parameter int E_WIDTH = 16,
  parameter int IDX_W   = $clog2(E_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_e,
  input  logic [E_WIDTH-1:0] e_in,
  input  logic               start,
  input  logic               op_done,
  output logic               busy,
  output logic               init_acc,
  output logic               op_start,
  output logic               op_sel,
  output logic [IDX_W-1:0]   bit_idx,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    SQ_ISSUE  = 3'd2,
    SQ_WAIT   = 3'd3,
    MUL_ISSUE = 3'd4,
    MUL_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t             state;
  logic [E_WIDTH-1:0] e_reg;
  logic [E_WIDTH-1:0] shadow;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  function automatic logic [IDX_W-1:0] msb_idx(input logic [E_WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < E_WIDTH; i++) begin
      if (v[i]) msb_idx = IDX_W'(i);
    end
  endfunction
`endif

  // Moore outputs straight from the state register.
  assign busy     = (state != IDLE);
  assign init_acc = (state == INIT);
  assign op_start = (state == SQ_ISSUE) || (state == MUL_ISSUE);
  assign op_sel   = (state == MUL_ISSUE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      e_reg   <= '0;
      shadow  <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_e) e_reg <= e_in;
          if (start) begin
            // The run works on a snapshot so later loads cannot disturb it.
            shadow  <= load_e ? e_in : e_reg;
            bit_idx <= IDX_W'(E_WIDTH - 1);
            state   <= INIT;
          end
        end
        INIT: begin
          if (shadow == '0) begin
            state <= DONE;
          end else begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            bit_idx <= msb_idx(shadow);
`endif
            state <= SQ_ISSUE;
          end
        end
        SQ_ISSUE: state <= SQ_WAIT;
        SQ_WAIT: begin
          if (op_done) begin
            if (shadow[bit_idx]) begin
              state <= MUL_ISSUE;
            end else if (bit_idx == '0) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
              state   <= SQ_ISSUE;
            end
          end
        end
        MUL_ISSUE: state <= MUL_WAIT;
        MUL_WAIT: begin
          if (op_done) begin
            // Zero check first so bit_idx never wraps.
            if (bit_idx == '0) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
              state   <= SQ_ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer (E_WIDTH=4): a datapath model answers each op_start one
// cycle later; events are checked against hand-computed expectations in a queue.
module tb_modexp_sequencer;
  localparam int EW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_e = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] e_in = '0;
  logic          op_done;
  logic          busy, init_acc, op_start, op_sel, done;
  logic [IW-1:0] bit_idx;

  logic dp_saw = 1'b0;
  logic dp_done = 1'b0;
  logic inj_done = 1'b0;
  assign op_done = dp_done | inj_done;

  int cyc = 0;
  int start_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  modexp_sequencer #(.E_WIDTH(EW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .load_e(load_e), .e_in(e_in), .start(start),
    .op_done(op_done), .busy(busy), .init_acc(init_acc), .op_start(op_start),
    .op_sel(op_sel), .bit_idx(bit_idx), .done(done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath model: op_done is high during the cycle after op_start
  always @(negedge clk) begin
    dp_done <= dp_saw;
    dp_saw  <= op_start;
  end

  // event word: {type[2:0], op_sel, bit_idx[1:0], rel_cycle[9:0]}; 1=init 2=op 3=done
  function automatic logic [15:0] mk(input int t, input logic s, input logic [1:0] i, input int rel);
    mk = {3'(t), s, i, 10'(rel)};
  endfunction

  task automatic exp_init();
    exp_q.push_back(mk(1, 1'b0, 2'd0, 1));
  endtask
  task automatic exp_op(input logic s, input logic [1:0] i, input int rel);
    exp_q.push_back(mk(2, s, i, rel));
  endtask
  task automatic exp_done(input int rel);
    exp_q.push_back(mk(3, 1'b0, 2'd0, rel));
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // scoreboard monitor
  task automatic check_ev(input logic [15:0] got);
    logic [15:0] want;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got type=%0d sel=%0d idx=%0d rel=%0d, want none",
               got[15:13], got[12], got[11:10], got[9:0]);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL event: got type=%0d sel=%0d idx=%0d rel=%0d, want type=%0d sel=%0d idx=%0d rel=%0d",
                 got[15:13], got[12], got[11:10], got[9:0],
                 want[15:13], want[12], want[11:10], want[9:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (init_acc) check_ev(mk(1, 1'b0, 2'd0, cyc - start_cyc));
    if (op_start) check_ev(mk(2, op_sel, bit_idx, cyc - start_cyc));
    if (done)     check_ev(mk(3, 1'b0, 2'd0, cyc - start_cyc));
  end

  // driver tasks
  task automatic do_load(input logic [EW-1:0] ev);
    @(negedge clk);
    load_e = 1'b1; e_in = ev;
    @(negedge clk);
    load_e = 1'b0; e_in = '0;
  endtask

  task automatic do_start(input logic ld, input logic [EW-1:0] ev);
    @(negedge clk);
    load_e = ld; e_in = ev; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    load_e = 1'b0; e_in = '0; start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    if (seen) chk({name, "_busy_with_done"}, int'(busy), 1);
    @(negedge clk);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic exp_run_0001();
    exp_init();
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    exp_op(1'b0, 2'd0, 2); exp_op(1'b1, 2'd0, 4); exp_done(6);
`else
    exp_op(1'b0, 2'd3, 2); exp_op(1'b0, 2'd2, 4); exp_op(1'b0, 2'd1, 6);
    exp_op(1'b0, 2'd0, 8); exp_op(1'b1, 2'd0, 10); exp_done(12);
`endif
  endtask

  initial begin
    bit found;
    // reset block
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, init_acc, op_start, op_sel, done, bit_idx}), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); inj_done = 1'b1;
      @(negedge clk); inj_done = 1'b0;
      chk("idle_op_done_busy", int'(busy), 0);
    end
    chk("idle_outputs", int'({busy, init_acc, op_start, op_sel, done, bit_idx}), 0);

    // e = 1011, loaded in a separate cycle before start
    do_load(4'b1011);
    exp_init();
    exp_op(1'b0, 2'd3, 2);  exp_op(1'b1, 2'd3, 4);  exp_op(1'b0, 2'd2, 6);
    exp_op(1'b0, 2'd1, 8);  exp_op(1'b1, 2'd1, 10); exp_op(1'b0, 2'd0, 12);
    exp_op(1'b1, 2'd0, 14); exp_done(16);
    do_start(1'b0, 4'b0000);
    wait_done("e1011");

    // e = 0: no operations
    exp_init(); exp_done(2);
    do_start(1'b1, 4'b0000);
    wait_done("e0000");

    // e = 0011
    exp_init();
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    exp_op(1'b0, 2'd1, 2); exp_op(1'b1, 2'd1, 4); exp_op(1'b0, 2'd0, 6);
    exp_op(1'b1, 2'd0, 8); exp_done(10);
`else
    exp_op(1'b0, 2'd3, 2); exp_op(1'b0, 2'd2, 4);  exp_op(1'b0, 2'd1, 6);
    exp_op(1'b1, 2'd1, 8); exp_op(1'b0, 2'd0, 10); exp_op(1'b1, 2'd0, 12);
    exp_done(14);
`endif
    do_start(1'b1, 4'b0011);
    wait_done("e0011");

    // same-cycle load+start overrides old 1111; loads/starts while busy are ignored
    do_load(4'b1111);
    exp_run_0001();
    do_start(1'b1, 4'b0001);
    @(negedge clk);
    load_e = 1'b1; e_in = 4'b1111; start = 1'b1;
    @(negedge clk);
    load_e = 1'b0; e_in = '0; start = 1'b0;
    wait_done("load_start_same");
    exp_run_0001();
    do_start(1'b0, 4'b0000);
    wait_done("busy_load_ignored");

    // reset during MUL_WAIT aborts without done and clears the register
    exp_run_0001();
    do_start(1'b0, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (op_start && op_sel) found = 1'b1;
    end
    chk("mul_issue_seen", int'(found), 1);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("abort_outputs", int'({busy, init_acc, op_start, op_sel, done, bit_idx}), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    rst = 1'b0;
    exp_init(); exp_done(2);
    do_start(1'b0, 4'b1111);
    wait_done("after_abort_e0");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
